game_target_motion: RTL and testbench

//  Owns position and direction of every target sprite and advances them once per frame.

---
 rtl/game_target_motion.sv | 188 ++++++++++++++++++
 tb/tb_game_target_motion.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_target_motion.sv
// Target sprite motion: per-target position/direction registers, advanced one target per clock
// by a sweep started on frame_tick, with edge/collision bounces and a spawn/teleport port.
`ifndef N_TARGETS
`define N_TARGETS 4
`endif

module game_target_motion #(
    parameter int N_TARGETS = `N_TARGETS,
    parameter int W_X       = 10,
    parameter int W_Y       = 9,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SPRITE_W  = 16,
    parameter int SPRITE_H  = 16,
    parameter int SPEED     = 1,
    parameter int W_IDX     = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_tick,
    input  logic [N_TARGETS-1:0]              enable_targets,
    input  logic [N_TARGETS-1:0]              collide_x,
    input  logic [N_TARGETS-1:0]              collide_y,
    input  logic                              spawn_valid,
    output logic                              spawn_ready,
    input  logic [W_IDX-1:0]                  spawn_idx,
    input  logic [W_X-1:0]                    spawn_x,
    input  logic [W_Y-1:0]                    spawn_y,
    input  logic [1:0]                        spawn_dir,
    output logic [N_TARGETS-1:0][W_X-1:0]     sprite_left,
    output logic [N_TARGETS-1:0][W_X-1:0]     sprite_right,
    output logic [N_TARGETS-1:0][W_Y-1:0]     sprite_top,
    output logic [N_TARGETS-1:0][W_Y-1:0]     sprite_bottom,
    output logic                              busy,
    output logic                              update_done
);

    localparam int WA = ((W_X > W_Y) ? W_X : W_Y) + 1;
    localparam logic [W_X-1:0] X_MAX = W_X'(SCREEN_W - SPRITE_W);
    localparam logic [W_Y-1:0] Y_MAX = W_Y'(SCREEN_H - SPRITE_H);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                        state_r, state_n;
    logic [W_IDX-1:0]              idx_r, idx_n;
    logic [N_TARGETS-1:0][W_X-1:0] x_r;
    logic [N_TARGETS-1:0][W_Y-1:0] y_r;
    logic [N_TARGETS-1:0]          dxn_r, dyn_r, pend_x_r, pend_y_r;

    logic [WA:0]       step_x_s, step_y_s;
    logic [W_X-1:0]    nx_x_s, sp_x_s;
    logic [W_Y-1:0]    nx_y_s, sp_y_s;
    logic              nx_dxn_s, nx_dyn_s, flip_dxn_s, flip_dyn_s;
    logic              spawn_hit_s, updating_s;
    logic              unused_s;

    // Move one axis by SPEED in the given direction; result is {new_neg, new_pos}, clamped to [0, lim].
    function automatic logic [WA:0] step_axis(input logic [WA-1:0] pos, input logic neg,
                                              input logic [WA-1:0] lim);
        logic [WA:0] r;
        if (neg) begin
            if (pos <= WA'(SPEED)) r = {1'b0, {WA{1'b0}}};
            else                   r = {1'b1, pos - WA'(SPEED)};
        end else begin
            if (pos + WA'(SPEED) >= lim) r = {1'b0, lim} | {1'b1, {WA{1'b0}}};
            else                         r = {1'b0, pos + WA'(SPEED)};
        end
        return r;
    endfunction

    assign updating_s  = (state_r == ST_UPDATE);
    assign spawn_ready = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign update_done = (state_r == ST_DONE);
    assign spawn_hit_s = spawn_valid && spawn_ready && (int'(spawn_idx) < N_TARGETS);
    assign sp_x_s      = (spawn_x > X_MAX) ? X_MAX : spawn_x;
    assign sp_y_s      = (spawn_y > Y_MAX) ? Y_MAX : spawn_y;

    // Next position/direction of the target currently addressed by the sweep.
    always_comb begin
        flip_dxn_s = dxn_r[idx_r] ^ pend_x_r[idx_r];
        flip_dyn_s = dyn_r[idx_r] ^ pend_y_r[idx_r];
        step_x_s   = step_axis(WA'(x_r[idx_r]), flip_dxn_s, WA'(X_MAX));
        step_y_s   = step_axis(WA'(y_r[idx_r]), flip_dyn_s, WA'(Y_MAX));
        nx_x_s     = step_x_s[W_X-1:0];
        nx_y_s     = step_y_s[W_Y-1:0];
        nx_dxn_s   = step_x_s[WA];
        nx_dyn_s   = step_y_s[WA];
    end

    assign unused_s = ^{step_x_s[WA-1:W_X], step_y_s[WA-1:W_Y]};

    // Sweep FSM next-state logic.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_n = ST_UPDATE;
                    idx_n   = {W_IDX{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                if (idx_r == W_IDX'(N_TARGETS - 1)) begin
                    state_n = ST_DONE;
                    idx_n   = {W_IDX{1'b0}};
                end else begin
                    idx_n   = idx_r + W_IDX'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                idx_n   = {W_IDX{1'b0}};
            end
        endcase
    end

    // Sweep FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {W_IDX{1'b0}};
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
        end
    end

    // Position/direction registers; spawn only happens in IDLE so it never meets a sweep write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r   <= '0;
            y_r   <= '0;
            dxn_r <= '0;
            dyn_r <= '0;
        end else begin
            for (int i = 0; i < N_TARGETS; i++) begin
                if (spawn_hit_s && (spawn_idx == W_IDX'(i))) begin
                    x_r[i]   <= sp_x_s;
                    y_r[i]   <= sp_y_s;
                    dxn_r[i] <= spawn_dir[0];
                    dyn_r[i] <= spawn_dir[1];
                end else if (updating_s && (idx_r == W_IDX'(i)) && enable_targets[i]) begin
                    x_r[i]   <= nx_x_s;
                    y_r[i]   <= nx_y_s;
                    dxn_r[i] <= nx_dxn_s;
                    dyn_r[i] <= nx_dyn_s;
                end
            end
        end
    end

    // Collision pending flags: a pulse landing on the consume cycle survives to the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_x_r <= '0;
            pend_y_r <= '0;
        end else begin
            for (int i = 0; i < N_TARGETS; i++) begin
                if (spawn_hit_s && (spawn_idx == W_IDX'(i))) begin
                    pend_x_r[i] <= 1'b0;
                    pend_y_r[i] <= 1'b0;
                end else begin
                    pend_x_r[i] <= (pend_x_r[i] & ~(updating_s && (idx_r == W_IDX'(i)))) | collide_x[i];
                    pend_y_r[i] <= (pend_y_r[i] & ~(updating_s && (idx_r == W_IDX'(i)))) | collide_y[i];
                end
            end
        end
    end

    for (genvar g = 0; g < N_TARGETS; g++) begin : g_box
        assign sprite_left[g]   = x_r[g];
        assign sprite_right[g]  = x_r[g] + W_X'(SPRITE_W);
        assign sprite_top[g]    = y_r[g];
        assign sprite_bottom[g] = y_r[g] + W_Y'(SPRITE_H);
    end

endmodule

// File: tb/tb_game_target_motion.sv
// Self-checking bench for game_target_motion: directed table, corner sequences and a
// randomized run against a frame-level reference model.
`ifndef N_TARGETS
`define N_TARGETS 4
`endif

module tb_game_target_motion;

    localparam int N    = `N_TARGETS;
    localparam int W_X  = 10;
    localparam int W_Y  = 9;
    localparam int WI   = (N > 1) ? $clog2(N) : 1;
    localparam int XMAX = 640 - 16;
    localparam int YMAX = 480 - 16;
    localparam int SPD  = 1;
    localparam int SPR  = 16;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      frame_tick = 1'b0;
    logic [N-1:0]              enable_targets = '1;
    logic [N-1:0]              collide_x = '0;
    logic [N-1:0]              collide_y = '0;
    logic                      spawn_valid = 1'b0;
    logic                      spawn_ready;
    logic [WI-1:0]             spawn_idx = '0;
    logic [W_X-1:0]            spawn_x = '0;
    logic [W_Y-1:0]            spawn_y = '0;
    logic [1:0]                spawn_dir = 2'b00;
    logic [N-1:0][W_X-1:0]     sprite_left, sprite_right;
    logic [N-1:0][W_Y-1:0]     sprite_top, sprite_bottom;
    logic                      busy, update_done;

    game_target_motion dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable_targets(enable_targets),
        .collide_x(collide_x), .collide_y(collide_y), .spawn_valid(spawn_valid),
        .spawn_ready(spawn_ready), .spawn_idx(spawn_idx), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .spawn_dir(spawn_dir), .sprite_left(sprite_left), .sprite_right(sprite_right),
        .sprite_top(sprite_top), .sprite_bottom(sprite_bottom), .busy(busy),
        .update_done(update_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: positions, directions, pending bounces and sweep progress
    // (mode -1 = idle, 0..N-1 = target written at the next edge, N = done cycle).
    int mx[N], my[N];
    bit mdx[N], mdy[N], mpx[N], mpy[N];
    int mode;

    typedef struct {
        int       sx, sy;
        bit [1:0] dir;
        int       ticks;
        int       ex, ey;
    } vec_t;
    vec_t tbl[10];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0; mpx[i] = 0; mpy[i] = 0;
        end
        mode = -1;
    endtask

    task automatic axis(input int p, input bit n, input int lim, output int po, output bit no);
        if (n) begin
            if (p <= SPD) begin po = 0; no = 0; end
            else begin po = p - SPD; no = 1; end
        end else begin
            if (p + SPD >= lim) begin po = lim; no = 1; end
            else begin po = p + SPD; no = 0; end
        end
    endtask

    task automatic model_edge();
        int k, si, po;
        bit no;
        k = (mode >= 0 && mode < N) ? mode : -1;
        if (k >= 0 && enable_targets[k]) begin
            mdx[k] ^= mpx[k];
            mdy[k] ^= mpy[k];
            axis(mx[k], mdx[k], XMAX, po, no); mx[k] = po; mdx[k] = no;
            axis(my[k], mdy[k], YMAX, po, no); my[k] = po; mdy[k] = no;
        end
        for (int i = 0; i < N; i++) begin
            mpx[i] = ((i == k) ? 1'b0 : mpx[i]) | collide_x[i];
            mpy[i] = ((i == k) ? 1'b0 : mpy[i]) | collide_y[i];
        end
        si = int'(spawn_idx);
        if (spawn_valid && mode == -1 && si < N) begin
            mx[si]  = (int'(spawn_x) > XMAX) ? XMAX : int'(spawn_x);
            my[si]  = (int'(spawn_y) > YMAX) ? YMAX : int'(spawn_y);
            mdx[si] = spawn_dir[0];
            mdy[si] = spawn_dir[1];
            mpx[si] = 0;
            mpy[si] = 0;
        end
        if (mode == -1)     mode = frame_tick ? 0 : -1;
        else if (mode == N) mode = -1;
        else                mode = mode + 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One vector: every output against the model.
    task automatic check_all();
        string what;
        int a, e;
        bit bad;
        bad = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (int'(sprite_left[i])   != mx[i])       begin bad = 1; what = $sformatf("left[%0d]", i);   a = int'(sprite_left[i]);   e = mx[i];       end
            if (int'(sprite_right[i])  != mx[i] + SPR) begin bad = 1; what = $sformatf("right[%0d]", i);  a = int'(sprite_right[i]);  e = mx[i] + SPR; end
            if (int'(sprite_top[i])    != my[i])       begin bad = 1; what = $sformatf("top[%0d]", i);    a = int'(sprite_top[i]);    e = my[i];       end
            if (int'(sprite_bottom[i]) != my[i] + SPR) begin bad = 1; what = $sformatf("bottom[%0d]", i); a = int'(sprite_bottom[i]); e = my[i] + SPR; end
        end
        if (busy != (mode != -1))        begin bad = 1; what = "busy";        a = busy;        e = (mode != -1); end
        if (update_done != (mode == N))  begin bad = 1; what = "update_done"; a = update_done; e = (mode == N);  end
        if (spawn_ready != (mode == -1)) begin bad = 1; what = "spawn_ready"; a = spawn_ready; e = (mode == -1); end
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL model %s: got %0d, expected %0d (t=%0t)", what, a, e, $time);
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic frame();
        int seen, at;
        seen = 0; at = -1;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        for (int c = 1; c <= N + 1; c++) begin
            cyc();
            if (update_done) begin seen++; at = c; end
        end
        chk("done_count", seen, 1);
        chk("done_cycle", at, N);
    endtask

    task automatic spawn(input int idx, input int x, input int y, input bit [1:0] dir);
        spawn_valid = 1'b1;
        spawn_idx   = WI'(idx);
        spawn_x     = W_X'(x);
        spawn_y     = W_Y'(y);
        spawn_dir   = dir;
        cyc();
        spawn_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{100, 50, 2'b00, 3, 103, 53};
        tbl[1] = '{623, 10, 2'b00, 1, 624, 11};
        tbl[2] = '{623, 10, 2'b00, 2, 623, 12};
        tbl[3] = '{1, 1, 2'b11, 1, 0, 0};
        tbl[4] = '{1, 1, 2'b11, 2, 1, 1};
        tbl[5] = '{1000, 500, 2'b00, 0, 624, 464};
        tbl[6] = '{624, 464, 2'b00, 1, 624, 464};
        tbl[7] = '{624, 464, 2'b11, 1, 623, 463};
        tbl[8] = '{0, 0, 2'b00, 1, 1, 1};
        tbl[9] = '{10, 463, 2'b01, 1, 9, 464};

        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("reset_right0", int'(sprite_right[0]), SPR);
        chk("reset_ready", spawn_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table on target 0.
        for (int v = 0; v < 10; v++) begin
            spawn(0, tbl[v].sx, tbl[v].sy, tbl[v].dir);
            for (int t = 0; t < tbl[v].ticks; t++) frame();
            chk($sformatf("tbl%0d_left", v),  int'(sprite_left[0]),  tbl[v].ex);
            chk($sformatf("tbl%0d_top", v),   int'(sprite_top[0]),   tbl[v].ey);
            chk($sformatf("tbl%0d_right", v), int'(sprite_right[0]), tbl[v].ex + SPR);
        end

        // Collision flags in IDLE flip target 1, then are gone.
        spawn(1, 200, 200, 2'b00);
        collide_x[1] = 1'b1; collide_y[1] = 1'b1;
        cyc();
        collide_x = '0; collide_y = '0;
        frame();
        chk("coll_x", int'(sprite_left[1]), 199);
        chk("coll_y", int'(sprite_top[1]), 199);
        frame();
        chk("coll_x2", int'(sprite_left[1]), 198);

        // Pulse on the exact cycle target 2 is written is deferred one frame.
        spawn(2, 300, 300, 2'b00);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc(); cyc();
        collide_x[2] = 1'b1;
        cyc();
        collide_x = '0;
        for (int c = 0; c < N - 2; c++) cyc();
        chk("race_frame1", int'(sprite_left[2]), 301);
        chk("race_idle", busy, 0);
        frame();
        chk("race_frame2", int'(sprite_left[2]), 300);

        // Disabled target is frozen and its pending flag is dropped.
        spawn(3, 50, 50, 2'b00);
        enable_targets[3] = 1'b0;
        collide_x[3] = 1'b1;
        cyc();
        collide_x = '0;
        frame();
        chk("dis_frozen", int'(sprite_left[3]), 50);
        enable_targets[3] = 1'b1;
        frame();
        chk("dis_resume", int'(sprite_left[3]), 51);

        // frame_tick and spawn while busy are ignored.
        frame_tick = 1'b1;
        cyc();
        spawn_valid = 1'b1; spawn_idx = '0; spawn_x = W_X'(5); spawn_y = W_Y'(5);
        cyc();
        chk("busy_ready", spawn_ready, 0);
        spawn_valid = 1'b0;
        frame_tick = 1'b0;
        for (int c = 0; c < N; c++) cyc();
        chk("busy_noextra", busy, 0);

        // Spawn and tick together: sweep uses spawned values.
        spawn_valid = 1'b1; spawn_idx = '0; spawn_x = W_X'(400); spawn_y = W_Y'(100); spawn_dir = 2'b00;
        frame_tick = 1'b1;
        cyc();
        spawn_valid = 1'b0; frame_tick = 1'b0;
        for (int c = 0; c < N + 1; c++) cyc();
        chk("sp_tick_x", int'(sprite_left[0]), 401);

        // Reset in the middle of a sweep.
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc(); cyc();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_bottom", int'(sprite_bottom[1]), SPR);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            frame_tick  = ($urandom_range(0, 7) == 0);
            spawn_valid = ($urandom_range(0, 5) == 0);
            spawn_idx   = WI'($urandom);
            spawn_x     = W_X'($urandom);
            spawn_y     = W_Y'($urandom);
            spawn_dir   = 2'($urandom);
            collide_x   = N'($urandom) & N'($urandom) & N'($urandom);
            collide_y   = N'($urandom) & N'($urandom) & N'($urandom);
            if ($urandom_range(0, 49) == 0) enable_targets = N'($urandom) | N'($urandom);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
